// File: rtl/rom_burst_arbiter_if.sv
// Bundle between the ROM burst arbiter, its two requesters, the ROM and the response consumer.
// The slave modport is the arbiter's view; the master modport is the surrounding logic's view.
interface rom_burst_arbiter_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 5
);
   logic              req0_valid;
   logic              req0_ready;
   logic [ADDR_W-1:0] req0_addr;
   logic [LEN_W-1:0]  req0_len;
   logic              req1_valid;
   logic              req1_ready;
   logic [ADDR_W-1:0] req1_addr;
   logic [LEN_W-1:0]  req1_len;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_id;
   logic              rsp_last;
   logic              busy;

   modport slave (
      input  req0_valid, req0_addr, req0_len,
      input  req1_valid, req1_addr, req1_len,
      input  rom_data, rsp_ready,
      output req0_ready, req1_ready, rom_addr,
      output rsp_valid, rsp_data, rsp_id, rsp_last, busy
   );

   modport master (
      output req0_valid, req0_addr, req0_len,
      output req1_valid, req1_addr, req1_len,
      output rom_data, rsp_ready,
      input  req0_ready, req1_ready, rom_addr,
      input  rsp_valid, rsp_data, rsp_id, rsp_last, busy
   );
endinterface

// File: rtl/rom_burst_arbiter.sv
// Round-robin burst reader sharing one combinational ROM between two requesters; read data
// streams out through a single registered, ID-tagged valid/ready response stage.
module rom_burst_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 5
) (
   input logic                clk,
   input logic                rst,
   rom_burst_arbiter_if.slave bus
);
   typedef enum logic {
      S_IDLE,
      S_BURST
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_cur_addr;
   logic [LEN_W-1:0]  r_remaining;
   logic              r_id;
   logic              r_last_grant;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_data;
   logic              r_rsp_id;
   logic              r_rsp_last;

   logic              w_gnt0;
   logic              w_gnt1;
   logic              w_load;
   logic              w_free;
   logic              w_final;

   // The response register can take a new beat when empty or when its beat leaves this edge.
   assign w_free  = ~r_rsp_valid | bus.rsp_ready;
   assign w_final = (r_remaining == '0);

   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      // NOTE: each signal driven here gets a default first, so no path can infer a latch.
      w_state_nxt = r_state;
      w_gnt0      = 1'b0;
      w_gnt1      = 1'b0;
      w_load      = 1'b0;
      case (r_state)
         S_IDLE: begin
            // On a tie the requester that did not win last time is served.
            w_gnt0 = bus.req0_valid & (~bus.req1_valid | r_last_grant);
            w_gnt1 = bus.req1_valid & (~bus.req0_valid | ~r_last_grant);
            if (w_gnt0 || w_gnt1) begin
               w_state_nxt = S_BURST;
            end
         end
         S_BURST: begin
            w_load = w_free;
            if (w_free && w_final) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cur_addr   <= '0;
         r_remaining  <= '0;
         r_id         <= 1'b0;
         r_last_grant <= 1'b1;
         r_rsp_valid  <= 1'b0;
         r_rsp_data   <= '0;
         r_rsp_id     <= 1'b0;
         r_rsp_last   <= 1'b0;
      end else begin
         if (w_gnt0) begin
            r_cur_addr   <= bus.req0_addr;
            r_remaining  <= bus.req0_len;
            r_id         <= 1'b0;
            r_last_grant <= 1'b0;
         end else if (w_gnt1) begin
            r_cur_addr   <= bus.req1_addr;
            r_remaining  <= bus.req1_len;
            r_id         <= 1'b1;
            r_last_grant <= 1'b1;
         end else if (w_load && !w_final) begin
            r_cur_addr  <= r_cur_addr + ADDR_W'(1);
            r_remaining <= r_remaining - LEN_W'(1);
         end

         if (w_load) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= bus.rom_data;
            r_rsp_id    <= r_id;
            r_rsp_last  <= w_final;
         end else if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
         end
      end
   end

   assign bus.req0_ready = w_gnt0;
   assign bus.req1_ready = w_gnt1;
   assign bus.rom_addr   = r_cur_addr;
   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_data   = r_rsp_data;
   assign bus.rsp_id     = r_rsp_id;
   assign bus.rsp_last   = r_rsp_last;
   assign bus.busy       = (r_state == S_BURST);
endmodule

// File: doc/rom_burst_arbiter.md
Name: rom_burst_arbiter

Overview:
- Shares one combinational-read ROM (2^ADDR_W words × DATA_W) between two requesters.
- Each requester issues burst reads (start address + length); round-robin arbitration decides which one is served.
- The block drives the ROM address and streams registered read data back on one shared response channel, tagged with the requester ID, with valid/ready backpressure.
- It sits between the ROM instance and its consumers in the top level and replaces the free-running address counter.

Parameters:
ADDR_W, 5, ROM address width (32 words)
DATA_W, 32, ROM/response data width
LEN_W, 5, burst length field width; encodes beats−1

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
req0_valid  in  1  requester 0 burst request
req0_ready  out  1  requester 0 request accepted this cycle
req0_addr  in  ADDR_W  requester 0 start address
req0_len  in  LEN_W  requester 0 beats−1
req1_valid  in  1  requester 1 burst request
req1_ready  out  1  requester 1 request accepted this cycle
req1_addr  in  ADDR_W  requester 1 start address
req1_len  in  LEN_W  requester 1 beats−1
rom_addr  out  ADDR_W  address to ROM
rom_data  in  DATA_W  ROM read data, combinational from rom_addr
rsp_valid  out  1  response beat valid
rsp_ready  in  1  consumer accepts beat
rsp_data  out  DATA_W  response data
rsp_id  out  1  requester that owns the beat
rsp_last  out  1  final beat of burst
busy  out  1  high while state is BURST

Behaviour:
- Reset (rst=0 at posedge) sets:
  - state=IDLE
  - rsp_valid=0, rsp_last=0, rsp_id=0, rsp_data=0
  - rom_addr=0 (cur_addr register), remaining=0
  - last_grant=1, so requester 0 wins the first tie
  - busy=0
- Reset mid-burst aborts the burst and discards any held beat; no further beats of that burst are produced.
- State IDLE:
  - reqN_ready is combinational and high only for the granted requester.
  - Grant rule: if only one reqN_valid is high, grant it. If both are high, grant the requester ≠ last_grant.
  - An accepted request (reqN_valid & reqN_ready) latches:
    - cur_addr ← reqN_addr
    - remaining ← reqN_len
    - id ← N
    - last_grant ← N
    - state ← BURST
  - Both ready outputs are 0 in BURST.
- Requester rules: reqN_addr and reqN_len stay stable while reqN_valid is high and not yet accepted. Deasserting valid before acceptance is legal.
- State BURST:
  - rom_addr = cur_addr.
  - Output register "free" means rsp_valid=0 or rsp_ready=1.
  - When free, on posedge: rsp_data←rom_data, rsp_id←id, rsp_last←(remaining==0), rsp_valid←1.
  - If remaining==0: state←IDLE. Otherwise cur_addr←cur_addr+1 (mod 2^ADDR_W) and remaining←remaining−1.
- Output register not free (backpressure): rsp_data, rsp_id, rsp_last and rsp_valid hold exactly; cur_addr and remaining hold.
- When a beat is consumed (rsp_ready=1) and no new beat loads that edge, rsp_valid←0 and rsp_last←0.
- Latency and throughput:
  - Request accepted at cycle T → first beat valid at T+2.
  - With rsp_ready held high, throughput is 1 beat/cycle.
  - Last beat loaded at X → next request can be accepted at X+1 → its first beat at X+3 (one bubble between bursts).
- A new request can be accepted in IDLE while the previous last beat is still stalled. The new burst does not load until the register is free.
- Address wrap: 31+1 → 0, with no error.
- Burst sizes: len=0 gives 1 beat; len=2^LEN_W−1 gives 32 beats.

Test Plan:
- Single burst: req0 addr=3 len=2, rsp_ready=1, accepted at T → rsp_data=mem[3],mem[4],mem[5] at T+2,T+3,T+4; rsp_last only at T+4; rsp_id=0; busy high T+1..T+3.
- Arbitration: both valid from reset (req0 addr=0 len=0, req1 addr=8 len=0) held continuously → grants alternate 0,1,0,1; response rsp_id sequence 0,1,0,1; a bubble between beats.
- Wrap: req1 addr=30 len=3 → data mem[30],mem[31],mem[0],mem[1]; rsp_id=1; rsp_last on mem[1].
- Backpressure: req0 addr=4 len=3, rsp_ready low for 3 cycles after first beat → mem[4] held stable 4 cycles, rom_addr stays 5. Then all four beats arrive in order, none lost or duplicated.
- Busy blocking: req1_valid raised during req0 burst → req1_ready stays 0 until IDLE, then req1 accepted the next cycle.
- Reset mid-burst: rst=0 on 2nd beat of len=5 burst → next cycle rsp_valid=0, busy=0, rom_addr=0. After release, a req1/req0 tie grants req0.
